control_unit: RTL and testbench

Instruction sequencer for the 4-bit CPU, sitting directly upstream of `program_counter`. It latches each 8-bit instruction fetched from instruction memory at the address on `pc_out`. It steps a three-state FETCH/DECODE/EXECUTE machine and generates the `pc_inc`, `pc_load` and `pc_in` controls that `program_counter` consumes, along with the ALU, accumulator and data-RAM strobes. One instruction completes every 3 cycles until HLT.

---
 rtl/control_unit.sv | 105 ++++++++++
 tb/tb_control_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Instruction sequencer for the 4-bit CPU: latches the fetched instruction and
// steps FETCH/DECODE/EXECUTE, producing PC, ALU, accumulator and RAM strobes.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   FETCH   | wait for run; on run latch instr into IR, bump PC
//   DECODE  | no strobes; pick EXECUTE, or HALT for opcode F
//   EXECUTE | one-cycle strobes for the opcode in IR
//   HALT    | absorbing, halted=1; left only through reset
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       zero_flag,
  input  logic       carry_flag,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [3:0] pc_in,
  output logic [3:0] operand,
  output logic [2:0] alu_op,
  output logic       acc_load,
  output logic       mem_we,
  output logic       halted,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_DECODE  = 2'b01,
    S_EXECUTE = 2'b10,
    S_HALT    = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    alu_op   = 3'b000;
    acc_load = 1'b0;
    mem_we   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = instr;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (ir_q[7:4] == 4'hF) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_FETCH;
        case (ir_q[7:4])
          4'h1: begin acc_load = 1'b1; alu_op = 3'b000; end
          4'h2: begin acc_load = 1'b1; alu_op = 3'b001; end
          4'h3: begin acc_load = 1'b1; alu_op = 3'b010; end
          4'h4: begin acc_load = 1'b1; alu_op = 3'b011; end
          4'h5: begin acc_load = 1'b1; alu_op = 3'b100; end
          4'h6: begin acc_load = 1'b1; alu_op = 3'b101; end
          4'h7: begin acc_load = 1'b1; alu_op = 3'b110; end
          4'h8: mem_we  = 1'b1;
          4'h9: pc_load = 1'b1;
          4'hA: pc_load = zero_flag;
          4'hB: pc_load = carry_flag;
          default: ;
        endcase
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase

    // Reset suppresses strobes combinationally so a reset landing on
    // EXECUTE cannot commit that instruction's side effects.
    if (reset) begin
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      alu_op   = 3'b000;
      acc_load = 1'b0;
      mem_we   = 1'b0;
    end
  end

  assign pc_in   = ir_q[3:0];
  assign operand = ir_q[3:0];
  assign halted  = (state_q == S_HALT);
  assign state   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each driven cycle pushes its expected
// output vector, which is popped and compared mid-cycle on the falling edge.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset, run, zero_flag, carry_flag;
  logic [7:0] instr;
  logic       pc_inc, pc_load, acc_load, mem_we, halted;
  logic [3:0] pc_in, operand;
  logic [2:0] alu_op;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [17:0] vec;
  } exp_t;

  exp_t sb[$];

  logic [3:0] pc_model;
  logic       pc_set;

  always #5 clk = ~clk;

  control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .instr      (instr),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .operand    (operand),
    .alu_op     (alu_op),
    .acc_load   (acc_load),
    .mem_we     (mem_we),
    .halted     (halted),
    .state      (state)
  );

  // Stand-in for program_counter so jump behaviour is visible on a PC value.
  always @(posedge clk) begin
    if (pc_set)       pc_model <= 4'd4;
    else if (pc_load) pc_model <= pc_in;
    else if (pc_inc)  pc_model <= pc_model + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {state, halted, pc_inc, pc_load, acc_load, mem_we, alu_op, pc_in, operand}
  function automatic logic [17:0] e(input logic [1:0] st, input logic hlt,
                                    input logic inc, input logic ld, input logic acc,
                                    input logic we, input logic [2:0] op,
                                    input logic [3:0] nib);
    return {st, hlt, inc, ld, acc, we, op, nib, nib};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check(x.tag, {14'd0, state, halted, pc_inc, pc_load, acc_load, mem_we,
                    alu_op, pc_in, operand}, {14'd0, x.vec});
    end
  end

  task automatic cyc(input string tag, input logic rst, input logic rn,
                     input logic [7:0] ins, input logic zf, input logic cf,
                     input logic [17:0] exp);
    exp_t x;
    @(posedge clk);
    #1;
    reset      = rst;
    run        = rn;
    instr      = ins;
    zero_flag  = zf;
    carry_flag = cf;
    x.tag = tag;
    x.vec = exp;
    sb.push_back(x);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; instr = 8'h00; zero_flag = 1'b0; carry_flag = 1'b0;
    pc_set = 1'b0;
    repeat (2) @(posedge clk);

    cyc("rst_cycle",    1, 1, 8'h13, 0, 0, e(2'd0, 0, 0, 0, 0, 0, 3'b000, 4'h0));
    cyc("ldi_fetch",    0, 1, 8'h13, 0, 0, e(2'd0, 0, 1, 0, 0, 0, 3'b000, 4'h0));
    cyc("ldi_decode",   0, 1, 8'h13, 0, 0, e(2'd1, 0, 0, 0, 0, 0, 3'b000, 4'h3));
    cyc("ldi_exec",     0, 1, 8'h13, 0, 0, e(2'd2, 0, 0, 0, 1, 0, 3'b000, 4'h3));
    pc_set = 1'b1;

    cyc("jmp_fetch",    0, 1, 8'h99, 0, 0, e(2'd0, 0, 1, 0, 0, 0, 3'b000, 4'h3));
    pc_set = 1'b0;
    check("pc_start", {28'd0, pc_model}, 32'd4);
    cyc("jmp_decode",   0, 1, 8'h99, 0, 0, e(2'd1, 0, 0, 0, 0, 0, 3'b000, 4'h9));
    check("pc_after_fetch", {28'd0, pc_model}, 32'd5);
    cyc("jmp_exec",     0, 1, 8'h99, 0, 0, e(2'd2, 0, 0, 1, 0, 0, 3'b000, 4'h9));

    cyc("jz0_fetch",    0, 1, 8'hA6, 0, 0, e(2'd0, 0, 1, 0, 0, 0, 3'b000, 4'h9));
    check("pc_after_jmp", {28'd0, pc_model}, 32'd9);
    cyc("jz0_decode",   0, 1, 8'hA6, 0, 0, e(2'd1, 0, 0, 0, 0, 0, 3'b000, 4'h6));
    cyc("jz0_exec",     0, 1, 8'hA6, 0, 1, e(2'd2, 0, 0, 0, 0, 0, 3'b000, 4'h6));
    cyc("jz1_fetch",    0, 1, 8'hA6, 0, 0, e(2'd0, 0, 1, 0, 0, 0, 3'b000, 4'h6));
    cyc("jz1_decode",   0, 1, 8'hA6, 0, 0, e(2'd1, 0, 0, 0, 0, 0, 3'b000, 4'h6));
    cyc("jz1_exec",     0, 1, 8'hA6, 1, 0, e(2'd2, 0, 0, 1, 0, 0, 3'b000, 4'h6));
    cyc("jc0_fetch",    0, 1, 8'hB6, 0, 0, e(2'd0, 0, 1, 0, 0, 0, 3'b000, 4'h6));
    cyc("jc0_decode",   0, 1, 8'hB6, 0, 0, e(2'd1, 0, 0, 0, 0, 0, 3'b000, 4'h6));
    cyc("jc0_exec",     0, 1, 8'hB6, 1, 0, e(2'd2, 0, 0, 0, 0, 0, 3'b000, 4'h6));
    cyc("jc1_fetch",    0, 1, 8'hB6, 0, 0, e(2'd0, 0, 1, 0, 0, 0, 3'b000, 4'h6));
    cyc("jc1_decode",   0, 1, 8'hB6, 0, 0, e(2'd1, 0, 0, 0, 0, 0, 3'b000, 4'h6));
    cyc("jc1_exec",     0, 1, 8'hB6, 0, 1, e(2'd2, 0, 0, 1, 0, 0, 3'b000, 4'h6));

    for (int i = 0; i < 4; i++)
      cyc("stall",      0, 0, 8'h85, 0, 0, e(2'd0, 0, 0, 0, 0, 0, 3'b000, 4'h6));
    cyc("sta_fetch",    0, 1, 8'h85, 0, 0, e(2'd0, 0, 1, 0, 0, 0, 3'b000, 4'h6));
    cyc("sta_decode",   0, 0, 8'h00, 0, 0, e(2'd1, 0, 0, 0, 0, 0, 3'b000, 4'h5));
    cyc("sta_exec",     0, 1, 8'h00, 0, 0, e(2'd2, 0, 0, 0, 0, 1, 3'b000, 4'h5));

    cyc("xor_fetch",    0, 1, 8'h6A, 0, 0, e(2'd0, 0, 1, 0, 0, 0, 3'b000, 4'h5));
    cyc("xor_decode",   0, 1, 8'h6A, 0, 0, e(2'd1, 0, 0, 0, 0, 0, 3'b000, 4'hA));
    cyc("xor_exec",     0, 1, 8'h6A, 0, 0, e(2'd2, 0, 0, 0, 1, 0, 3'b101, 4'hA));
    cyc("lda_fetch",    0, 1, 8'h7C, 0, 0, e(2'd0, 0, 1, 0, 0, 0, 3'b000, 4'hA));
    cyc("lda_decode",   0, 1, 8'h7C, 0, 0, e(2'd1, 0, 0, 0, 0, 0, 3'b000, 4'hC));
    cyc("lda_exec",     0, 1, 8'h7C, 0, 0, e(2'd2, 0, 0, 0, 1, 0, 3'b110, 4'hC));
    cyc("sub_fetch",    0, 1, 8'h32, 0, 0, e(2'd0, 0, 1, 0, 0, 0, 3'b000, 4'hC));
    cyc("sub_decode",   0, 1, 8'h32, 0, 0, e(2'd1, 0, 0, 0, 0, 0, 3'b000, 4'h2));
    cyc("sub_exec",     0, 1, 8'h32, 0, 0, e(2'd2, 0, 0, 0, 1, 0, 3'b010, 4'h2));
    cyc("rsv_fetch",    0, 1, 8'hD1, 0, 0, e(2'd0, 0, 1, 0, 0, 0, 3'b000, 4'h2));
    cyc("rsv_decode",   0, 1, 8'hD1, 1, 1, e(2'd1, 0, 0, 0, 0, 0, 3'b000, 4'h1));
    cyc("rsv_exec",     0, 1, 8'hD1, 1, 1, e(2'd2, 0, 0, 0, 0, 0, 3'b000, 4'h1));

    cyc("hlt_fetch",    0, 1, 8'hF0, 0, 0, e(2'd0, 0, 1, 0, 0, 0, 3'b000, 4'h1));
    cyc("hlt_decode",   0, 1, 8'hF0, 0, 0, e(2'd1, 0, 0, 0, 0, 0, 3'b000, 4'h0));
    for (int i = 0; i < 10; i++)
      cyc("halted",     0, 1, 8'h13, 1, 1, e(2'd3, 1, 0, 0, 0, 0, 3'b000, 4'h0));
    cyc("hlt_reset",    1, 1, 8'h13, 0, 0, e(2'd3, 1, 0, 0, 0, 0, 3'b000, 4'h0));
    cyc("post_reset",   0, 0, 8'h27, 0, 0, e(2'd0, 0, 0, 0, 0, 0, 3'b000, 4'h0));

    cyc("add_fetch",    0, 1, 8'h27, 0, 0, e(2'd0, 0, 1, 0, 0, 0, 3'b000, 4'h0));
    cyc("add_decode",   0, 1, 8'h27, 0, 0, e(2'd1, 0, 0, 0, 0, 0, 3'b000, 4'h7));
    cyc("add_exec_rst", 1, 1, 8'h27, 0, 0, e(2'd2, 0, 0, 0, 0, 0, 3'b000, 4'h7));
    cyc("add_after",    0, 0, 8'h00, 0, 0, e(2'd0, 0, 0, 0, 0, 0, 3'b000, 4'h0));

    @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
